// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
//   Shared definitions for the bit-serial arithmetic blocks.
//   - DEFAULT_WIDTH : default operand width for serial datapaths
//   - state_t       : sequencer state encoding (IDLE / RUN / DONE)
//   - cnt_width()   : bit-counter width able to hold 0..w without wrapping
// -----------------------------------------------------------------------------
package arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// -----------------------------------------------------------------------------
// full_subtractor_bit
//   One-bit combinational full subtractor: {bout, d} = a - b - bin.
//   Ports:
//     a    in  minuend bit
//     b    in  subtrahend bit
//     bin  in  borrow-in
//     d    out difference bit
//     bout out borrow-out
// -----------------------------------------------------------------------------
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign d     = w_axb ^ bin;
  // Borrow when a<b outright, or when a==b and a borrow is already pending.
  assign bout  = (~a & b) | (~w_axb & bin);

endmodule

// File: rtl/serial_full_subtractor.sv
// -----------------------------------------------------------------------------
// serial_full_subtractor
//   Bit-serial ripple-borrow subtractor: diff = a - b - bin (mod 2^WIDTH),
//   one bit per clock, LSB first, with a registered borrow.
//   Operands enter through a valid/ready handshake in IDLE, WIDTH RUN cycles
//   compute the result, and DONE presents it until the consumer accepts.
//   Ports:
//     clk        in  rising-edge clock
//     rst_n      in  asynchronous active-low reset
//     in_valid   in  operands presented
//     in_ready   out operands can be accepted (IDLE only)
//     a, b       in  minuend / subtrahend, WIDTH bits
//     bin        in  borrow-in
//     out_valid  out result available (DONE)
//     out_ready  in  consumer accepts result
//     diff       out a - b - bin, WIDTH bits, held until the next DONE
//     bout       out borrow-out (unsigned underflow)
//     ovf        out signed overflow of a - b (bin folds into diff only)
//     busy       out high while RUN
// -----------------------------------------------------------------------------
module serial_full_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned   CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_br;
  logic             r_bout;
  logic             r_ovf;
  logic             r_amsb;
  logic             r_bmsb;
  logic [CW-1:0]    r_cnt;

  logic             w_d;
  logic             w_br_nxt;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  full_subtractor_bit u_bit (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_br_nxt)
  );

  assign w_accept  = (r_state == IDLE) && in_valid;
  assign w_last    = (r_state == RUN) && (r_cnt == LAST_BIT);
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_BIT) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Serial datapath. The shifting result register is private; the visible
  // diff/bout/ovf registers load only on the final RUN cycle, so they stay
  // frozen through DONE, IDLE and the next RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_diff <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= a;
        r_b    <= b;
        r_br   <= bin;
        r_res  <= '0;
        r_cnt  <= '0;
        // Operand MSBs are shifted out during RUN; keep them for ovf.
        r_amsb <= a[WIDTH-1];
        r_bmsb <= b[WIDTH-1];
      end else if (r_state == RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_br  <= w_br_nxt;
        r_res <= w_res_nxt;
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_diff <= w_res_nxt;
          r_bout <= w_br_nxt;
          // w_d is the result MSB on the last bit.
          r_ovf  <= (r_amsb != r_bmsb) && (w_d != r_amsb);
        end
      end
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule

// File: doc/serial_full_subtractor.md
Name: serial_full_subtractor

Overview:
Bit-serial ripple-borrow subtractor. It computes diff = a - b - bin over WIDTH bits, one bit per clock, LSB first, using a registered borrow. It is the inverse-direction companion to the combinational full-adder cells in the arithmetic set. It sits behind a valid/ready input and a valid/ready output, so it can be dropped into area-constrained datapaths.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands presented
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  borrow-out (unsigned underflow)
ovf  output  1  signed (two's-complement) overflow
busy  output  1  high in RUN

Behaviour:
- One clock `clk`. Asynchronous, active-low reset `rst_n`.
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, diff=0, bout=0, ovf=0, bit counter=0, shift regs=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at a rising edge: latch a, b into shift regs, borrow reg <= bin, count <= 0, go to RUN.
- RUN: each cycle:
  - d = a[0] ^ b[0] ^ br
  - br' = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br)
  - d shifts into the MSB of the result reg; a and b shift right.
  - count increments.
  - After exactly WIDTH RUN cycles, go to DONE.
- DONE:
  - out_valid=1; diff, bout=final br, and ovf are stable and held.
  - On out_valid && out_ready: go to IDLE, out_valid drops next cycle.
  - diff, bout and ovf keep their values in IDLE until the next DONE.
- Latency: out_valid rises WIDTH cycles after the accepting edge. Minimum initiation interval is WIDTH+2 cycles; there is no accept in the same cycle as the output handshake.
- ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the latched a and b MSBs. bin is included in diff only.
- in_valid during RUN or DONE is ignored (in_ready=0); the operands must be re-presented.
- out_ready is ignored outside DONE.
- Back-pressure: DONE holds indefinitely; no results are dropped or overwritten.
- Reset mid-RUN or mid-DONE aborts the operation; all outputs take their reset values immediately.
- Counter width is clog2(WIDTH)+1; there is no wrap within one operation.

Decomposition:
- Shared package `arith_pkg`: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
- One combinational sub-module `full_subtractor_bit` (a, b, bin -> d, bout) instantiated once in the RUN datapath. It is reusable and independently testable against the exhaustive 8-row truth table.

Test Plan:
1. WIDTH=8, a=0x05, b=0x03, bin=0 -> diff=0x02, bout=0, ovf=0; out_valid exactly 8 cycles after the accept edge.
2. a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0.
3. a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1, ovf=0; a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
4. Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, diff/bout/ovf stable. Assert in_valid with new operands during RUN -> in_ready=0 and the operands are not taken.
5. Assert rst_n=0 at RUN bit 3 -> out_valid=0, busy=0, diff=0, in_ready=1 without waiting for a clock. After release, a fresh 0x10-0x01 gives 0x0F.
6. Full-coverage sweep of full_subtractor_bit (8 rows), plus 1000 random a/b/bin triples with random out_ready stalls -> every result matches the reference model.
